ast_bob_line_doubler: RTL and testbench
=======================================

// Module: ast_bob_line_doubler
// PURPOSE
// Avalon-ST video stage directly downstream of the BT.656-to-AST converter. It consumes
// interlaced fields, one control packet plus one video packet each (Y only, e.g. 720x288).
// Each field is turned into a progressive frame of twice the height by emitting every line
// twice (bob). Needs a single line buffer; the control packet is rewritten to height*2,
// progressive; all other packet types pass through unchanged.
// PARAMETERS
// DATA_WIDTH  8    symbol width, one symbol per beat
// MAX_WIDTH   720  line buffer depth in pixels; also the maximum accepted line width
// PORTS
// clock               in   1           single clock for the whole block
// reset               in   1           synchronous, active-high
// din_data            in   DATA_WIDTH  sink data
// din_valid           in   1           sink valid
// din_startofpacket   in   1           sink SOP
// din_endofpacket     in   1           sink EOP
// din_ready           out  1           sink ready
// dout_data           out  DATA_WIDTH  source data (registered)
// dout_valid          out  1           source valid (registered)
// dout_startofpacket  out  1           source SOP (registered)
// dout_endofpacket    out  1           source EOP (registered)
// dout_ready          in   1           source ready
// field_parity        out  1           F bit of the last control packet (interlace nibble bit2)
// format_error        out  1           sticky; cleared only by reset
// BEHAVIOUR
// - Reset (synchronous): dout_valid/sop/eop=0, dout_data=0, din_ready=0, field_parity=0,
//   format_error=0, state=IDLE, all counters 0. Reset mid-packet discards the packet in flight.
// - Handshake: ready latency 0 on both sides; transfer = valid & ready. dout_* are held
//   stable while dout_valid & ~dout_ready. din_ready=0 when the output register is full
//   and not draining, and always in CTRL_OUT and REPEAT.
// - States:
//   IDLE: wait for SOP. Type 0xF goes to CTRL_IN, type 0x0 to VID_HDR, other types to
//     PASS_OTHER. A non-SOP beat in IDLE is dropped.
//   CTRL_IN: capture nibbles 1..9 into W[15:0], H[15:0], ilace[3:0]; nothing is output.
//     On EOP go to CTRL_OUT. EOP before 9 nibbles: forward the original ctrl packet
//     unchanged, set format_error, set bypass.
//   CTRL_OUT: emit 10 beats: 0x0F, W nibbles, (2*H)[15:0] nibbles, 4'h0; EOP on beat 10.
//     field_parity<=ilace[2]. If W==0, W>MAX_WIDTH or H==0: emit the original values
//     instead, set bypass and format_error.
//   VID_HDR: forward the type-0 SOP beat. bypass=1 -> PASS_OTHER, else LINE_PASS.
//   LINE_PASS: forward each pixel and write it to line_ram[px]. Pixel W-1 goes to REPEAT.
//     Input EOP on that pixel is masked and not forwarded.
//   REPEAT: din_ready=0. Replay line_ram[0..W-1]; RAM has 1-cycle read latency and the read
//     is prefetched so that output is 1 beat/cycle while dout_ready=1. After pixel W-1:
//     line<H-1 -> line++, LINE_PASS; else dout EOP on that beat and go to FLUSH.
//   FLUSH: if the input EOP was already seen -> IDLE. Otherwise consume and drop input
//     beats until EOP, set format_error (over-long field), then IDLE.
//   PASS_OTHER: forward beats unchanged until EOP, then IDLE; clears bypass only if this is
//     a video packet.
// - Early input EOP in LINE_PASS (short field): forward that beat with EOP, skip the
//   partial-line repeat, set format_error, go to IDLE.
// - SOP inside a packet: treated as data, no resync.
// - Counters: px 16 bits and line 16 bits, compare against W-1/H-1 held in registers.
//   2*H is taken mod 2^16. The line count per output frame is exactly 2*H.
// - Latency: pass-through 1 cycle din->dout. REPEAT starts on the cycle after the last
//   pass beat is accepted into the output register.
// - Throughput: 1 beat/cycle when dout_ready=1; input stalls for W cycles per line.
// STRUCTURE
// - Package ast_video_pkg: PKT_TYPE_VIDEO=4'h0, PKT_TYPE_CTRL=4'hF, CTRL_NIBBLES=9,
//   ILACE_PROGRESSIVE=4'h0, typedef enum state_t {IDLE, CTRL_IN, CTRL_OUT, VID_HDR,
//   LINE_PASS, REPEAT, FLUSH, PASS_OTHER}.
// - One sub-module, line_ram: simple dual-port MAX_WIDTH x DATA_WIDTH, registered read.
// - Everything else (FSM, counters, output register) lives in the top module.
// TESTING
// 1 Ctrl 0F,0,2,D,0,0,1,2,0,B -> out 0F,0,2,D,0,0,2,4,0,0; EOP beat 10;
//   field_parity=0. With last nibble F: field_parity=1.
// 2 Ctrl W=4,H=2; video 00,1..8 -> out 00(SOP),1,2,3,4,1,2,3,4,5,6,7,8,5,6,7,8;
//   EOP only on the final 8; din_ready=0 during both repeats.
// 3 Same as 2 with dout_ready toggled randomly 50% -> identical sequence; dout_* held
//   stable while stalled; no beat lost or duplicated.
// 4 Ctrl W=800 (>MAX_WIDTH) -> ctrl and video forwarded unchanged; format_error=1.
// 5 W=4,H=2, input EOP on pixel 6 -> out ...,1,2,3,4,5,6(EOP); IDLE; format_error=1.
//   With 3 extra beats after pixel 8: they are dropped, format_error=1.
// 6 Reset asserted mid-REPEAT -> next cycle all outputs 0; a new field afterwards
//   processes correctly. Packet type 0x3 between fields passes through unchanged.

Source files
------------

// File: rtl/ast_bob_line_doubler_pkg.sv
// Purpose : shared packet-type codes, control-packet sizing and FSM state encoding
//           for the Avalon-ST bob line doubler.
// Ports   : none (package).
package ast_video_pkg;

    localparam logic [3:0] PKT_TYPE_VIDEO    = 4'h0;
    localparam logic [3:0] PKT_TYPE_CTRL     = 4'hF;
    localparam int         CTRL_NIBBLES      = 9;
    localparam logic [3:0] ILACE_PROGRESSIVE = 4'h0;

    typedef enum logic [2:0] {
        IDLE,
        CTRL_IN,
        CTRL_OUT,
        VID_HDR,
        LINE_PASS,
        REPEAT,
        FLUSH,
        PASS_OTHER
    } state_t;

    // Control packets carry 16-bit fields as four nibbles, most significant first.
    function automatic logic [15:0] pack_nibbles(input logic [3:0] n3, input logic [3:0] n2,
                                                 input logic [3:0] n1, input logic [3:0] n0);
        return {n3, n2, n1, n0};
    endfunction

endpackage

// File: rtl/ast_bob_line_doubler_if.sv
// Purpose : one Avalon-ST stream (data, valid, sop, eop, ready), ready latency 0.
// Ports   : master drives data/valid/startofpacket/endofpacket and samples ready;
//           slave is the mirror image.
interface ast_bob_line_doubler_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  startofpacket;
    logic                  endofpacket;
    logic                  ready;

    modport master (output data, output valid, output startofpacket, output endofpacket,
                    input  ready);
    modport slave  (input  data, input  valid, input  startofpacket, input  endofpacket,
                    output ready);
endinterface

// File: rtl/ast_bob_line_doubler_line_ram.sv
// Purpose : simple dual-port line store, one write and one read port.
// Latency : registered read, data appears the cycle after re; rdata holds while re=0.
// Backpressure: none; the caller throttles re.
// Ports   : clock; we/waddr/wdata write port; re/raddr/rdata read port.
module line_ram #(
    parameter int DEPTH      = 720,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 10
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ast_bob_line_doubler.sv
// Purpose : bob deinterlacer; each field line is emitted twice and the control packet is
//           rewritten to height*2 / progressive. Other packet types pass unchanged.
// Latency : 1 cycle din->dout for pass beats; a line replay starts the cycle after its last
//           pixel is taken. Backpressure: dout_ready stalls everything; din is held off while
//           a line is replayed or the control packet is re-emitted.
// Ports   : clock, reset (sync, active high); din (sink) / dout (source) streams;
//           field_parity = F bit of last control packet; format_error = sticky error flag.
module ast_bob_line_doubler
    import ast_video_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WIDTH  = 720
) (
    input  logic                    clock,
    input  logic                    reset,
    ast_bob_line_doubler_if.slave   din,
    ast_bob_line_doubler_if.master  dout,
    output logic                    field_parity,
    output logic                    format_error
);

    localparam int AW         = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int CTRL_BEATS = CTRL_NIBBLES + 1;

    state_t                state;
    logic [DATA_WIDTH-1:0] out_dat;
    logic                  out_vld, out_sop, out_eop;

    logic [DATA_WIDTH-1:0] ctrl_beat [CTRL_BEATS];
    logic [3:0]            ctrl_len;     // beats captured, header included, saturating
    logic [3:0]            ctrl_idx;     // beat being re-emitted

    logic [15:0] w_m1, h_m1, px, line, rd_ptr;
    logic        geom_ok;     // a valid geometry has been latched since reset
    logic        bypass;      // last control packet was unusable: pass next video as-is
    logic        pass_vid;    // PASS_OTHER is carrying a video packet
    logic        eop_seen;    // input EOP arrived on the last pixel of a line
    logic        rd_done, rdata_vld;

    logic                  din_rdy, acc, can_load, rd_en, consume, wr_en;
    logic [DATA_WIDTH-1:0] rdata, ctrl_out_dat;
    logic [15:0]           w_c, h_c, h2;
    logic                  ctrl_full, geom_good, ctrl_last;

    function automatic logic [DATA_WIDTH-1:0] zx(input logic [3:0] n);
        logic [DATA_WIDTH-1:0] r;
        r      = '0;
        r[3:0] = n;
        return r;
    endfunction

    // The output register can take a new beat when empty or draining this cycle.
    assign can_load = ~out_vld | dout.ready;

    always_comb begin
        din_rdy = 1'b0;
        case (state)
            IDLE:       din_rdy = ~din.startofpacket;   // stray non-SOP beats are dropped
            CTRL_IN:    din_rdy = 1'b1;
            VID_HDR,
            LINE_PASS,
            PASS_OTHER: din_rdy = can_load;
            FLUSH:      din_rdy = ~eop_seen;
            default:    din_rdy = 1'b0;
        endcase
        if (reset) din_rdy = 1'b0;
    end

    assign din.ready = din_rdy;
    assign acc       = din.valid & din_rdy;

    assign dout.data          = out_dat;
    assign dout.valid         = out_vld;
    assign dout.startofpacket = out_sop;
    assign dout.endofpacket   = out_eop;

    // Control-packet decode straight from the captured beats.
    assign w_c = pack_nibbles(ctrl_beat[1][3:0], ctrl_beat[2][3:0],
                              ctrl_beat[3][3:0], ctrl_beat[4][3:0]);
    assign h_c = pack_nibbles(ctrl_beat[5][3:0], ctrl_beat[6][3:0],
                              ctrl_beat[7][3:0], ctrl_beat[8][3:0]);
    assign h2        = {h_c[14:0], 1'b0};
    assign ctrl_full = (ctrl_len == 4'(CTRL_BEATS));
    assign geom_good = ctrl_full && (w_c != 16'd0) && (w_c <= 16'(MAX_WIDTH)) && (h_c != 16'd0);
    assign ctrl_last = (ctrl_idx == ctrl_len - 4'd1);

    always_comb begin
        ctrl_out_dat = ctrl_beat[ctrl_idx];
        if (geom_good) begin
            case (ctrl_idx)
                4'd0:    ctrl_out_dat = zx(PKT_TYPE_CTRL);
                4'd1,
                4'd2,
                4'd3,
                4'd4:    ctrl_out_dat = zx(ctrl_beat[ctrl_idx][3:0]);
                4'd5:    ctrl_out_dat = zx(h2[15:12]);
                4'd6:    ctrl_out_dat = zx(h2[11:8]);
                4'd7:    ctrl_out_dat = zx(h2[7:4]);
                4'd8:    ctrl_out_dat = zx(h2[3:0]);
                default: ctrl_out_dat = zx(ILACE_PROGRESSIVE);
            endcase
        end
    end

    // Replay read is prefetched: issue a read whenever the RAM output stage is empty or
    // is being consumed, so a line replays at one beat per cycle.
    assign consume = (state == REPEAT) & rdata_vld & can_load;
    assign rd_en   = (state == REPEAT) & ~rd_done & (~rdata_vld | consume);
    assign wr_en   = (state == LINE_PASS) & acc;

    line_ram #(
        .DEPTH      (MAX_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_line_ram (
        .clock (clock),
        .we    (wr_en),
        .waddr (px[AW-1:0]),
        .wdata (din.data),
        .re    (rd_en),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            out_dat      <= '0;
            out_vld      <= 1'b0;
            out_sop      <= 1'b0;
            out_eop      <= 1'b0;
            field_parity <= 1'b0;
            format_error <= 1'b0;
            for (int i = 0; i < CTRL_BEATS; i++) ctrl_beat[i] <= '0;
            ctrl_len     <= '0;
            ctrl_idx     <= '0;
            w_m1         <= '0;
            h_m1         <= '0;
            px           <= '0;
            line         <= '0;
            rd_ptr       <= '0;
            geom_ok      <= 1'b0;
            bypass       <= 1'b0;
            pass_vid     <= 1'b0;
            eop_seen     <= 1'b0;
            rd_done      <= 1'b0;
            rdata_vld    <= 1'b0;
        end else begin
            if (can_load) out_vld <= 1'b0;
            rdata_vld <= rd_en | (rdata_vld & ~consume);

            case (state)
                IDLE: begin
                    // Only peek at the SOP beat; the next state consumes it.
                    if (din.valid && din.startofpacket) begin
                        case (din.data[3:0])
                            PKT_TYPE_CTRL:  begin state <= CTRL_IN; ctrl_len <= '0; end
                            PKT_TYPE_VIDEO: state <= VID_HDR;
                            default:        begin state <= PASS_OTHER; pass_vid <= 1'b0; end
                        endcase
                    end
                end

                CTRL_IN: begin
                    if (acc) begin
                        if (ctrl_len < 4'(CTRL_BEATS)) begin
                            ctrl_beat[ctrl_len] <= din.data;
                            ctrl_len            <= ctrl_len + 4'd1;
                        end
                        if (din.endofpacket) begin
                            state    <= CTRL_OUT;
                            ctrl_idx <= '0;
                        end
                    end
                end

                CTRL_OUT: begin
                    if (geom_good) begin
                        field_parity <= ctrl_beat[CTRL_NIBBLES][2];
                        w_m1         <= w_c - 16'd1;
                        h_m1         <= h_c - 16'd1;
                        geom_ok      <= 1'b1;
                        bypass       <= 1'b0;
                    end else begin
                        format_error <= 1'b1;
                        bypass       <= 1'b1;
                        if (ctrl_full) field_parity <= ctrl_beat[CTRL_NIBBLES][2];
                    end
                    if (can_load) begin
                        out_vld  <= 1'b1;
                        out_dat  <= ctrl_out_dat;
                        out_sop  <= (ctrl_idx == 4'd0);
                        out_eop  <= ctrl_last;
                        ctrl_idx <= ctrl_idx + 4'd1;
                        if (ctrl_last) state <= IDLE;
                    end
                end

                VID_HDR: begin
                    if (acc) begin
                        out_vld <= 1'b1;
                        out_dat <= din.data;
                        out_sop <= din.startofpacket;
                        out_eop <= din.endofpacket;
                        if (din.endofpacket) begin
                            state  <= IDLE;
                            bypass <= 1'b0;
                        end else if (bypass || !geom_ok) begin
                            state    <= PASS_OTHER;
                            pass_vid <= 1'b1;
                        end else begin
                            state    <= LINE_PASS;
                            px       <= '0;
                            line     <= '0;
                            eop_seen <= 1'b0;
                        end
                    end
                end

                LINE_PASS: begin
                    if (acc) begin
                        out_vld <= 1'b1;
                        out_dat <= din.data;
                        out_sop <= 1'b0;
                        px      <= px + 16'd1;
                        if (px == w_m1) begin
                            // EOP on the last pixel is held back until the replay ends.
                            out_eop  <= 1'b0;
                            eop_seen <= din.endofpacket;
                            state    <= REPEAT;
                            px       <= '0;
                            rd_ptr   <= '0;
                            rd_done  <= 1'b0;
                        end else if (din.endofpacket) begin
                            // Short field: close the frame here, the partial line is not replayed.
                            out_eop      <= 1'b1;
                            format_error <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            out_eop <= 1'b0;
                        end
                    end
                end

                REPEAT: begin
                    if (rd_en) begin
                        rd_ptr <= rd_ptr + 16'd1;
                        if (rd_ptr == w_m1) rd_done <= 1'b1;
                    end
                    if (consume) begin
                        out_vld <= 1'b1;
                        out_dat <= rdata;
                        out_sop <= 1'b0;
                        out_eop <= 1'b0;
                        px      <= px + 16'd1;
                        if (px == w_m1) begin
                            px <= '0;
                            if (line == h_m1) begin
                                out_eop <= 1'b1;
                                state   <= FLUSH;
                            end else if (eop_seen) begin
                                // Field ended on a line boundary before H lines arrived.
                                out_eop      <= 1'b1;
                                format_error <= 1'b1;
                                state        <= IDLE;
                            end else begin
                                line  <= line + 16'd1;
                                state <= LINE_PASS;
                            end
                        end
                    end
                end

                FLUSH: begin
                    if (eop_seen) begin
                        state <= IDLE;
                    end else if (acc) begin
                        format_error <= 1'b1;
                        if (din.endofpacket) state <= IDLE;
                    end
                end

                PASS_OTHER: begin
                    if (acc) begin
                        out_vld <= 1'b1;
                        out_dat <= din.data;
                        out_sop <= din.startofpacket;
                        out_eop <= din.endofpacket;
                        if (din.endofpacket) begin
                            state <= IDLE;
                            if (pass_vid) bypass <= 1'b0;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ast_bob_line_doubler.sv
// Purpose : directed self-checking bench for ast_bob_line_doubler.
// Latency : n/a. Backpressure: dout ready is either held high or toggled at random.
// Ports   : none (top-level bench).
module tb_ast_bob_line_doubler;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic field_parity, format_error;

    ast_bob_line_doubler_if #(.DATA_WIDTH(8)) din_if ();
    ast_bob_line_doubler_if #(.DATA_WIDTH(8)) dout_if ();

    ast_bob_line_doubler #(
        .DATA_WIDTH (8),
        .MAX_WIDTH  (720)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .din          (din_if),
        .dout         (dout_if),
        .field_parity (field_parity),
        .format_error (format_error)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] got_q [$];
    logic [9:0] exp_q [$];
    int         stall_log [$];
    bit         rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sink-side ready driver.
    initial begin
        dout_if.ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            dout_if.ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: records accepted beats and checks that a stalled beat is held.
    initial begin : monitor
        logic [10:0] prev;
        bit          prev_stall;
        prev       = '0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("hold", 32'({dout_if.valid, dout_if.startofpacket,
                                     dout_if.endofpacket, dout_if.data}), 32'(prev));
                if (dout_if.valid && dout_if.ready)
                    got_q.push_back({dout_if.startofpacket, dout_if.endofpacket, dout_if.data});
                prev_stall = dout_if.valid && !dout_if.ready;
                prev       = {dout_if.valid, dout_if.startofpacket,
                              dout_if.endofpacket, dout_if.data};
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic s, input logic e);
        int stalls;
        din_if.data          = d;
        din_if.startofpacket = s;
        din_if.endofpacket   = e;
        din_if.valid         = 1'b1;
        stalls               = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (din_if.ready) begin
                @(posedge clock);
                #1;
                din_if.valid = 1'b0;
                stall_log.push_back(stalls);
                return;
            end
            stalls++;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: beat 0x%0h not accepted after %0d cycles, required <500", d, stalls);
        din_if.valid = 1'b0;
        stall_log.push_back(stalls);
    endtask

    task automatic send_pkt(input logic [7:0] b [$], input bit with_eop);
        for (int i = 0; i < b.size(); i++)
            send(b[i], i == 0, with_eop && (i == b.size() - 1));
    endtask

    task automatic exp_pkt(input logic [7:0] b [$]);
        for (int i = 0; i < b.size(); i++)
            exp_q.push_back({i == 0, i == b.size() - 1, b[i]});
    endtask

    task automatic check_stream(input string tag);
        int n;
        for (int i = 0; i < 3000 && got_q.size() < exp_q.size(); i++) @(negedge clock);
        repeat (20) @(negedge clock);
        chk($sformatf("%s_len", tag), 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    logic [7:0] v [$];
    logic [7:0] ctrl44_in  [$];
    logic [7:0] ctrl44_out [$];
    logic [7:0] vid8 [$];
    logic [7:0] vid8_out [$];

    initial begin
        din_if.valid         = 1'b0;
        din_if.data          = '0;
        din_if.startofpacket = 1'b0;
        din_if.endofpacket   = 1'b0;

        ctrl44_in  = '{8'h0F, 8'h0, 8'h0, 8'h0, 8'h4, 8'h0, 8'h0, 8'h0, 8'h2, 8'h0};
        ctrl44_out = '{8'h0F, 8'h0, 8'h0, 8'h0, 8'h4, 8'h0, 8'h0, 8'h0, 8'h4, 8'h0};
        vid8       = '{8'h00, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h7, 8'h8};
        vid8_out   = '{8'h00, 8'h1, 8'h2, 8'h3, 8'h4, 8'h1, 8'h2, 8'h3, 8'h4,
                       8'h5, 8'h6, 8'h7, 8'h8, 8'h5, 8'h6, 8'h7, 8'h8};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", 32'(dout_if.valid), 32'd0);
        chk("rst_sop",   32'(dout_if.startofpacket), 32'd0);
        chk("rst_eop",   32'(dout_if.endofpacket), 32'd0);
        chk("rst_data",  32'(dout_if.data), 32'd0);
        chk("rst_ready", 32'(din_if.ready), 32'd0);
        chk("rst_fpar",  32'(field_parity), 32'd0);
        chk("rst_ferr",  32'(format_error), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // 1: 720x288 control packet rewritten to 576 lines, progressive
        v = '{8'h0F, 8'h0, 8'h2, 8'hD, 8'h0, 8'h0, 8'h1, 8'h2, 8'h0, 8'hB};
        send_pkt(v, 1'b1);
        v = '{8'h0F, 8'h0, 8'h2, 8'hD, 8'h0, 8'h0, 8'h2, 8'h4, 8'h0, 8'h0};
        exp_pkt(v);
        check_stream("t1_ctrl");
        chk("t1_fpar", 32'(field_parity), 32'd0);
        chk("t1_ferr", 32'(format_error), 32'd0);
        v = '{8'h0F, 8'h0, 8'h2, 8'hD, 8'h0, 8'h0, 8'h1, 8'h2, 8'h0, 8'hF};
        send_pkt(v, 1'b1);
        v = '{8'h0F, 8'h0, 8'h2, 8'hD, 8'h0, 8'h0, 8'h2, 8'h4, 8'h0, 8'h0};
        exp_pkt(v);
        check_stream("t1_ctrlF");
        chk("t1_fparF", 32'(field_parity), 32'd1);

        // 2: W=4, H=2 field doubled; input stalls during each replay
        send_pkt(ctrl44_in, 1'b1);
        exp_pkt(ctrl44_out);
        stall_log.delete();
        send_pkt(vid8, 1'b1);
        exp_pkt(vid8_out);
        v = '{8'h03, 8'hAA, 8'hBB};
        send_pkt(v, 1'b1);
        exp_pkt(v);
        check_stream("t2");
        chk("t2_stall_rep1", 32'(stall_log[5] >= 4), 32'd1);
        chk("t2_stall_rep2", 32'(stall_log[9] >= 4), 32'd1);
        chk("t2_ferr", 32'(format_error), 32'd0);

        // 3: same traffic with random output backpressure
        rand_rdy = 1'b1;
        send_pkt(ctrl44_in, 1'b1);
        exp_pkt(ctrl44_out);
        send_pkt(vid8, 1'b1);
        exp_pkt(vid8_out);
        check_stream("t3");
        rand_rdy = 1'b0;
        chk("t3_ferr", 32'(format_error), 32'd0);

        // 4: W=800 exceeds the line buffer, everything forwarded untouched
        v = '{8'h0F, 8'h0, 8'h3, 8'h2, 8'h0, 8'h0, 8'h0, 8'h2, 8'h0, 8'h0};
        send_pkt(v, 1'b1);
        exp_pkt(v);
        v = '{8'h00, 8'h1, 8'h2, 8'h3};
        send_pkt(v, 1'b1);
        exp_pkt(v);
        check_stream("t4");
        chk("t4_ferr", 32'(format_error), 32'd1);

        // 5a: short field, EOP on pixel 6
        do_reset();
        send_pkt(ctrl44_in, 1'b1);
        exp_pkt(ctrl44_out);
        v = '{8'h00, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6};
        send_pkt(v, 1'b1);
        v = '{8'h00, 8'h1, 8'h2, 8'h3, 8'h4, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6};
        exp_pkt(v);
        v = '{8'h03, 8'h11, 8'h22};
        send_pkt(v, 1'b1);
        exp_pkt(v);
        check_stream("t5a");
        chk("t5a_ferr", 32'(format_error), 32'd1);

        // 5b: over-long field, three extra beats dropped
        do_reset();
        send_pkt(ctrl44_in, 1'b1);
        exp_pkt(ctrl44_out);
        send_pkt(vid8, 1'b0);
        send(8'h9, 1'b0, 1'b0);
        send(8'hA, 1'b0, 1'b0);
        send(8'hB, 1'b0, 1'b1);
        exp_pkt(vid8_out);
        v = '{8'h03, 8'h33, 8'h44};
        send_pkt(v, 1'b1);
        exp_pkt(v);
        check_stream("t5b");
        chk("t5b_ferr", 32'(format_error), 32'd1);

        // 6: reset in the middle of a line replay, then a clean field
        do_reset();
        v = '{8'h0F, 8'h0, 8'h0, 8'h0, 8'h4, 8'h0, 8'h0, 8'h0, 8'h2, 8'h4};
        send_pkt(v, 1'b1);
        exp_pkt(ctrl44_out);
        check_stream("t6_ctrl");
        chk("t6_fpar_pre", 32'(field_parity), 32'd1);
        v = '{8'h00, 8'h1, 8'h2, 8'h3, 8'h4};
        send_pkt(v, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("t6_valid", 32'(dout_if.valid), 32'd0);
        chk("t6_sop",   32'(dout_if.startofpacket), 32'd0);
        chk("t6_eop",   32'(dout_if.endofpacket), 32'd0);
        chk("t6_data",  32'(dout_if.data), 32'd0);
        chk("t6_ready", 32'(din_if.ready), 32'd0);
        chk("t6_fpar",  32'(field_parity), 32'd0);
        chk("t6_ferr",  32'(format_error), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        send_pkt(ctrl44_in, 1'b1);
        exp_pkt(ctrl44_out);
        v = '{8'h03, 8'h55, 8'h66, 8'h77};
        send_pkt(v, 1'b1);
        exp_pkt(v);
        send_pkt(vid8, 1'b1);
        exp_pkt(vid8_out);
        check_stream("t6");
        chk("t6_ferr_end", 32'(format_error), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
